// File: rtl/mtm_alu_pkg.sv
// Shared constants, error-flag layout and the CRC4 step function for the serial ALU.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;

    localparam int FRAME_LEN = 11;

    // x^4 + x + 1 with the x^4 term implied
    localparam logic [3:0] CRC4_POLY = 4'h3;

    typedef struct packed {
        logic data;
        logic crc;
        logic op;
    } err_flags_t;

    function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic b);
        crc4_next = {crc[2:0], 1'b0} ^ ((crc[3] ^ b) ? CRC4_POLY : 4'h0);
    endfunction

    function automatic logic op_supported(input logic [2:0] op);
        op_supported = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mtm_alu_crc4_serial.sv
// Bit-serial CRC4 (x^4+x+1), MSB first, zero initial value; clear wins over enable.
module mtm_alu_crc4_serial
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       bit_i,
    output logic [3:0] crc_o
);

    logic [3:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i)
            crc_d = 4'h0;
        else if (enable_i)
            crc_d = crc4_next(crc_q, bit_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc_q <= 4'h0;
        else
            crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial ALU input stage: frame FSM, packet assembly, CRC/opcode checks, valid/ready output.
// Optional stop-bit checking is enabled with `define MTM_ALU_DESER_STOPCHK_EN.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
#(
    parameter int N_DATA_FRAMES = 8,
    parameter int CRC_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic        out_err_data,
    output logic        out_err_crc,
    output logic        out_err_op,
    output logic        out_ovf
);

    localparam int PAYLOAD_BITS = FRAME_LEN - 3;
    localparam int CNT_W        = $clog2(N_DATA_FRAMES + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_STOP = 3'd3;
`ifdef MTM_ALU_DESER_STOPCHK_EN
    localparam logic [2:0] S_WAIT = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             type_q, type_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [63:0]      shift_q, shift_d;

    logic [3:0]  crc, crc_tail;
    logic        crc_clr, crc_en;
    logic        done;
    err_flags_t  err;
    logic [2:0]  op_rx;

    logic        out_valid_q, out_valid_d;
    logic        ovf_q, ovf_d;
    logic        load;
    logic [31:0] out_a_q, out_b_q;
    logic [2:0]  out_op_q;
    err_flags_t  err_q;

    assign op_rx  = byte_q[6:4];
    assign crc_en = (state_q == S_DATA) && (type_q == FRAME_DATA);

    // The message trailer {1'b1, OP} is folded in combinationally so the result is ready at STOP.
    assign crc_tail = crc4_next(crc4_next(crc4_next(crc4_next(crc, 1'b1), op_rx[2]), op_rx[1]), op_rx[0]);

    mtm_alu_crc4_serial u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (crc_clr),
        .enable_i (crc_en),
        .bit_i    (sin),
        .crc_o    (crc)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        type_d      = type_q;
        byte_d      = byte_q;
        frame_cnt_d = frame_cnt_q;
        shift_d     = shift_q;
        done        = 1'b0;
        err         = '0;
        crc_clr     = 1'b0;
        case (state_q)
            S_IDLE: if (!sin) state_d = S_TYPE;
            S_TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                byte_d    = {byte_q[6:0], sin};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(PAYLOAD_BITS - 1)) state_d = S_STOP;
            end
            S_STOP: begin
                state_d = S_IDLE;
                if (type_q == FRAME_DATA) begin
                    if (frame_cnt_q == CNT_W'(N_DATA_FRAMES)) begin
                        done     = 1'b1;
                        err.data = 1'b1;
                    end else begin
                        shift_d     = {shift_q[55:0], byte_q};
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end else begin
                    done = 1'b1;
                    if (frame_cnt_q != CNT_W'(N_DATA_FRAMES))
                        err.data = 1'b1;
                    else if (byte_q[CRC_W-1:0] != crc_tail)
                        err.crc = 1'b1;
                    else if (!op_supported(op_rx))
                        err.op = 1'b1;
                end
`ifdef MTM_ALU_DESER_STOPCHK_EN
                if (!sin) begin
                    done     = 1'b1;
                    err      = '0;
                    err.data = 1'b1;
                    shift_d  = shift_q;
                    state_d  = S_WAIT;
                end
`endif
                if (done) begin
                    frame_cnt_d = '0;
                    crc_clr     = 1'b1;
                end
            end
`ifdef MTM_ALU_DESER_STOPCHK_EN
            S_WAIT: if (sin) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // A completion is taken if the slot is empty or being emptied this cycle, otherwise dropped.
    always_comb begin
        out_valid_d = out_valid_q;
        ovf_d       = 1'b0;
        load        = 1'b0;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (done) begin
            if (!out_valid_q || out_ready) begin
                load        = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            type_q      <= FRAME_DATA;
            byte_q      <= 8'h00;
            frame_cnt_q <= '0;
            shift_q     <= 64'h0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            type_q      <= type_d;
            byte_q      <= byte_d;
            frame_cnt_q <= frame_cnt_d;
            shift_q     <= shift_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            out_a_q     <= 32'h0;
            out_b_q     <= 32'h0;
            out_op_q    <= 3'b000;
            err_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            if (load) begin
                err_q <= err;
                if (type_q == FRAME_CMD) out_op_q <= op_rx;
                if (!(|err)) begin
                    out_a_q <= shift_q[31:0];
                    out_b_q <= shift_q[63:32];
                end
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_ovf      = ovf_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign out_op       = out_op_q;
    assign out_err_data = err_q.data;
    assign out_err_crc  = err_q.crc;
    assign out_err_op   = err_q.op;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Scoreboard bench for mtm_alu_deserializer: packets are serialised onto sin, results checked on handshake.
module tb_mtm_alu_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op;
    logic        out_err_data, out_err_crc, out_err_op, out_ovf;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   ovf_cnt = 0;

    mtm_alu_deserializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sin          (sin),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_op       (out_op),
        .out_err_data (out_err_data),
        .out_err_crc  (out_err_crc),
        .out_err_op   (out_err_op),
        .out_ovf      (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Long division of {B,A,1,OP} * x^4 by x^4+x+1
    function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [71:0] v;
        v = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (v[i]) v[i-:5] = v[i-:5] ^ 5'b10011;
        return v[3:0];
    endfunction

    always @(negedge clk) begin
        if (out_ovf) ovf_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("sb_pop", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("err_flags", {out_err_data, out_err_crc, out_err_op}, mon_e.err);
                if (mon_e.err == 3'b000) begin
                    check_val("out_a", out_a, mon_e.a);
                    check_val("out_b", out_b, mon_e.b);
                    check_val("out_op", out_op, mon_e.op);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic ftype, input logic [7:0] payload);
        send_bit(1'b0);
        send_bit(ftype);
        for (int i = 7; i >= 0; i--) send_bit(payload[i]);
        send_bit(1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_packet(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic [3:0] crc, input bit push);
        exp_t        e;
        logic [63:0] data;
        e.a = a;
        e.b = b;
        e.op = op;
        if (crc != ref_crc(a, b, op))
            e.err = 3'b010;
        else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101))
            e.err = 3'b001;
        else
            e.err = 3'b000;
        if (push) sb_q.push_back(e);
        data = {b, a};
        for (int i = 0; i < 8; i++) send_frame(1'b0, data[63-8*i -: 8]);
        send_frame(1'b1, {1'b0, op, crc});
    endtask

    task automatic good_packet(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        send_packet(a, b, op, ref_crc(a, b, op), 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        check_val("sb_drain", sb_q.size(), 0);
    endtask

    task automatic check_cleared(input string pfx);
        check_val({pfx, "_valid"}, out_valid, 0);
        check_val({pfx, "_a"}, out_a, 0);
        check_val({pfx, "_b"}, out_b, 0);
        check_val({pfx, "_op"}, out_op, 0);
        check_val({pfx, "_err"}, {out_err_data, out_err_crc, out_err_op}, 0);
        check_val({pfx, "_ovf"}, out_ovf, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, a1, b1;
        exp_t        e;

        repeat (3) @(posedge clk);
        #2;
        check_cleared("rst_hold");
        rst_n = 1'b1;
        idle(3);
        check_cleared("rst_idle");
        out_ready = 1'b1;

        a = $urandom;
        b = $urandom;
        good_packet(a, b, 3'b100);
        wait_drain();
        idle(2);

        good_packet(32'hFFFFFFFF, 32'h00000000, 3'b101);
        good_packet(32'hFFFFFFFF, 32'h00000000, 3'b000);
        good_packet(32'hFFFFFFFF, 32'h00000000, 3'b001);
        good_packet(32'hFFFFFFFF, 32'h00000000, 3'b100);
        wait_drain();

        send_packet(32'h11111111, 32'h22222222, 3'b100, 4'b0000, 1'b1);
        wait_drain();
        idle(2);

        e.a = 0; e.b = 0; e.op = 0; e.err = 3'b100;
        sb_q.push_back(e);
        for (int i = 0; i < 8; i++) send_frame(1'b0, 8'(8'hA0 + i));
        check_val("nine_pre_valid", out_valid, 0);
        send_frame(1'b0, 8'h5A);
        check_val("nine_valid_timing", out_valid, 1);
        check_val("nine_err_data", out_err_data, 1);
        wait_drain();
        idle(2);

        sb_q.push_back(e);
        for (int i = 0; i < 7; i++) send_frame(1'b0, 8'(8'h10 + i));
        send_frame(1'b1, {1'b0, 3'b100, 4'h0});
        wait_drain();
        idle(2);

        send_packet(32'h11111111, 32'h22222222, 3'b010, ref_crc(32'h11111111, 32'h22222222, 3'b010), 1'b1);
        wait_drain();
        good_packet(32'hCAFE0001, 32'h0BADF00D, 3'b001);
        wait_drain();
        idle(2);

        out_ready = 1'b0;
        ovf_cnt = 0;
        a1 = $urandom;
        b1 = $urandom;
        good_packet(a1, b1, 3'b100);
        send_packet(32'h12345678, 32'h9ABCDEF0, 3'b001, ref_crc(32'h12345678, 32'h9ABCDEF0, 3'b001), 1'b0);
        idle(3);
        check_val("ovf_pulses", ovf_cnt, 1);
        check_val("ovf_hold_valid", out_valid, 1);
        check_val("ovf_hold_a", out_a, a1);
        check_val("ovf_hold_b", out_b, b1);
        out_ready = 1'b1;
        wait_drain();
        idle(2);
        check_val("ovf_released", out_valid, 0);

        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h77);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_cleared("rst_mid");
        sin = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);
        good_packet(32'h0F0F0F0F, 32'hF0F0F0F0, 3'b101);
        wait_drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
